mips_pipe_ctrl: RTL

Pipeline sequencing and hazard control for the five-stage (IF/ID/EX/MEM/WB) MIPS core that succeeds the single-cycle top. It holds the inter-stage instruction/PC/valid registers and detects RAW and load-use hazards, producing stalls, bubbles and forwarding selects. It also handles flushes on taken branches/jumps resolved in EX and whole-pipe freezes while data memory is busy. It sits between IF and the ID/EX/DM datapath blocks, which keep their own data registers and take control from this block.

---
 rtl/mips_pipe_pkg.sv | 55 +++++
 rtl/mips_reg_use.sv | 61 ++++++
 rtl/mips_pipe_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared constants and types for the five-stage MIPS pipeline control.
// Opcode/funct values, forwarding select encodings and the per-stage register-use record.
package mips_pipe_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int REG_AW = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [REG_AW-1:0] REG_RA = 5'd31;
  localparam logic [DATA_W-1:0] NOP    = '0;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  // What the stage registers do on the next edge, in priority order.
  typedef enum logic [1:0] {
    ACT_ADVANCE  = 2'b00,
    ACT_FREEZE   = 2'b01,
    ACT_REDIRECT = 2'b10,
    ACT_STALL    = 2'b11
  } pipe_act_e;

  typedef struct packed {
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] dest;
    logic              uses_rs;
    logic              uses_rt;
    logic              writes_reg;
    logic              is_load;
  } reg_use_t;

  function automatic logic reads_reg(reg_use_t u, logic [REG_AW-1:0] r);
    return (u.uses_rs && (u.rs == r)) || (u.uses_rt && (u.rt == r));
  endfunction

endpackage

// File: rtl/mips_reg_use.sv
// Combinational register-use decode of one instruction: source fields, destination,
// and whether it writes a non-zero register or is a load.
module mips_reg_use
  import mips_pipe_pkg::*;
(
  input  logic [DATA_W-1:0] ins,
  output logic [REG_AW-1:0] rs,
  output logic [REG_AW-1:0] rt,
  output logic [REG_AW-1:0] dest,
  output logic              uses_rs,
  output logic              uses_rt,
  output logic              writes_reg,
  output logic              is_load
);

  logic [5:0] op;
  logic [5:0] funct;
  logic       wr;

  assign op      = ins[31:26];
  assign funct   = ins[5:0];
  assign rs      = ins[25:21];
  assign rt      = ins[20:16];
  assign is_load = (op == OP_LW);

  always_comb begin
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    wr      = 1'b0;
    dest    = '0;
    case (op)
      OP_RTYPE: begin
        uses_rs = 1'b1;
        if (funct != FN_JR) begin
          uses_rt = 1'b1;
          wr      = 1'b1;
          dest    = ins[15:11];
        end
      end
      OP_LW, OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: begin
        uses_rs = 1'b1;
        wr      = 1'b1;
        dest    = ins[20:16];
      end
      OP_JAL: begin
        wr   = 1'b1;
        dest = REG_RA;
      end
      OP_SW, OP_BEQ, OP_BNE: begin
        uses_rs = 1'b1;
        uses_rt = 1'b1;
      end
      OP_J: ;
      default: ;
    endcase
  end

  // $0 is hardwired, so writing it never creates a dependency.
  assign writes_reg = wr && (dest != '0);

endmodule

// File: rtl/mips_pipe_ctrl.sv
// Pipeline sequencing and hazard control for the five-stage MIPS core.
// Define MIPS_PIPE_FORWARD_EN for EX forwarding with load-use-only stalls; otherwise stall on any RAW.
module mips_pipe_ctrl
  import mips_pipe_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] if_ins,
  input  logic [ADDR_W-1:0] if_nextpc,
  input  logic              if_valid,
  input  logic              ex_br_taken,
  input  logic [ADDR_W-1:0] ex_newpc,
  input  logic              dm_busy,
  output logic [DATA_W-1:0] id_ins,
  output logic [DATA_W-1:0] ex_ins,
  output logic [DATA_W-1:0] mem_ins,
  output logic [DATA_W-1:0] wb_ins,
  output logic [ADDR_W-1:0] id_nextpc,
  output logic [ADDR_W-1:0] ex_nextpc,
  output logic              id_valid,
  output logic              ex_valid,
  output logic              mem_valid,
  output logic              wb_valid,
  output logic              pc_stall,
  output logic              pc_redirect,
  output logic [ADDR_W-1:0] pc_target,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  reg_use_t  use_id, use_ex, use_mem, use_wb;
  logic      ex_wr, mem_wr, wb_wr;
  logic      hazard;
  pipe_act_e act;
  logic      unused_ok;

  mips_reg_use u_use_id (
    .ins(id_ins), .rs(use_id.rs), .rt(use_id.rt), .dest(use_id.dest),
    .uses_rs(use_id.uses_rs), .uses_rt(use_id.uses_rt),
    .writes_reg(use_id.writes_reg), .is_load(use_id.is_load)
  );
  mips_reg_use u_use_ex (
    .ins(ex_ins), .rs(use_ex.rs), .rt(use_ex.rt), .dest(use_ex.dest),
    .uses_rs(use_ex.uses_rs), .uses_rt(use_ex.uses_rt),
    .writes_reg(use_ex.writes_reg), .is_load(use_ex.is_load)
  );
  mips_reg_use u_use_mem (
    .ins(mem_ins), .rs(use_mem.rs), .rt(use_mem.rt), .dest(use_mem.dest),
    .uses_rs(use_mem.uses_rs), .uses_rt(use_mem.uses_rt),
    .writes_reg(use_mem.writes_reg), .is_load(use_mem.is_load)
  );
  mips_reg_use u_use_wb (
    .ins(wb_ins), .rs(use_wb.rs), .rt(use_wb.rt), .dest(use_wb.dest),
    .uses_rs(use_wb.uses_rs), .uses_rt(use_wb.uses_rt),
    .writes_reg(use_wb.writes_reg), .is_load(use_wb.is_load)
  );

  assign ex_wr  = ex_valid  && use_ex.writes_reg;
  assign mem_wr = mem_valid && use_mem.writes_reg;
  assign wb_wr  = wb_valid  && use_wb.writes_reg;

`ifdef MIPS_PIPE_FORWARD_EN
  function automatic fwd_sel_e pick_fwd(logic used, logic [REG_AW-1:0] r);
    if (used && mem_wr && (r == use_mem.dest)) return FWD_MEM;
    if (used && wb_wr && (r == use_wb.dest))   return FWD_WB;
    return FWD_RF;
  endfunction

  // A load result is not ready until MEM completes, so only load-use must wait.
  assign hazard = id_valid && ex_wr && use_ex.is_load && reads_reg(use_id, use_ex.dest);
  assign fwd_a  = pick_fwd(ex_valid && use_ex.uses_rs, use_ex.rs);
  assign fwd_b  = pick_fwd(ex_valid && use_ex.uses_rt, use_ex.rt);
`else
  assign hazard = id_valid &&
                  ((ex_wr  && reads_reg(use_id, use_ex.dest))  ||
                   (mem_wr && reads_reg(use_id, use_mem.dest)) ||
                   (wb_wr  && reads_reg(use_id, use_wb.dest)));
  assign fwd_a  = FWD_RF;
  assign fwd_b  = FWD_RF;
`endif

  always_comb begin
    act = ACT_ADVANCE;
    if (dm_busy)                       act = ACT_FREEZE;
    else if (ex_br_taken && ex_valid)  act = ACT_REDIRECT;
    else if (hazard)                   act = ACT_STALL;
  end

  assign pc_stall    = RST && ((act == ACT_FREEZE) || (act == ACT_STALL));
  assign pc_redirect = RST && (act == ACT_REDIRECT);
  assign pc_target   = ex_newpc;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      id_ins    <= NOP;
      ex_ins    <= NOP;
      mem_ins   <= NOP;
      wb_ins    <= NOP;
      id_nextpc <= '0;
      ex_nextpc <= '0;
      id_valid  <= 1'b0;
      ex_valid  <= 1'b0;
      mem_valid <= 1'b0;
      wb_valid  <= 1'b0;
    end else if (act != ACT_FREEZE) begin
      mem_ins   <= ex_ins;
      mem_valid <= ex_valid;
      wb_ins    <= mem_ins;
      wb_valid  <= mem_valid;
      case (act)
        ACT_REDIRECT: begin
          id_ins    <= NOP;
          id_nextpc <= '0;
          id_valid  <= 1'b0;
          ex_ins    <= NOP;
          ex_nextpc <= '0;
          ex_valid  <= 1'b0;
        end
        ACT_STALL: begin
          ex_ins    <= NOP;
          ex_nextpc <= '0;
          ex_valid  <= 1'b0;
        end
        default: begin
          ex_ins    <= id_ins;
          ex_nextpc <= id_nextpc;
          ex_valid  <= id_valid;
          id_ins    <= if_ins;
          id_nextpc <= if_nextpc;
          id_valid  <= if_valid;
        end
      endcase
    end
  end

  // Not every decoded field is needed in every stage or build.
  assign unused_ok = ^{use_id, use_ex, use_mem, use_wb};

endmodule
